// File: rtl/icb_dma_master_pkg.sv
// Shared types and constants for the ICB DMA master.
//   dma_state_e : transfer FSM states
//   WMASK_FULL  : byte mask for a full 32-bit ICB write
//   BUS_STRIDE  : byte increment between consecutive 32-bit words on the bus
package acc_icb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSrd,
    StSlat,
    StCmd,
    StRsp,
    StFin
  } dma_state_e;

  localparam logic [3:0]  WMASK_FULL = 4'hF;
  localparam logic [31:0] BUS_STRIDE = 32'd4;

endpackage

// File: rtl/icb_dma_master_if.sv
// ICB command/response channel bundle.
//   master modport : DMA side (drives cmd_*, rsp_ready)
//   slave modport  : bus/memory side (drives cmd_ready, rsp_*)
interface icb_dma_master_if;

  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

endinterface

// File: rtl/icb_dma_master.sv
// Single-outstanding DMA engine between a local word SRAM and an ICB bus.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start/dir/...    : transfer request; dir 0 = bus->SRAM, 1 = SRAM->bus
//   busy/done/err    : status; done pulses one cycle, err sticky until next start
//   icb              : ICB master channel
//   sram_wr_* / rd_* : local SRAM ports, read data valid one cycle after rd_en
module icb_dma_master
  import acc_icb_pkg::*;
#(
  parameter int unsigned SRAM_AW = 13,
  parameter int unsigned LEN_W   = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               dir,
  input  logic [31:0]        bus_addr,
  input  logic [SRAM_AW-1:0] sram_addr,
  input  logic [LEN_W-1:0]   len_words,
  output logic               busy,
  output logic               done,
  output logic               err,
  icb_dma_master_if.master   icb,
  output logic               sram_wr_en,
  output logic [SRAM_AW-1:0] sram_wr_addr,
  output logic [31:0]        sram_wr_data,
  output logic               sram_rd_en,
  output logic [SRAM_AW-1:0] sram_rd_addr,
  input  logic [31:0]        sram_rd_data
);

  dma_state_e         state_q, state_d;
  logic               dir_q, dir_d;
  logic [31:0]        bus_addr_q, bus_addr_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic [31:0]        wbuf_q, wbuf_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               cmd_read_q, cmd_read_d;
  logic [31:0]        cmd_addr_q, cmd_addr_d;
  logic [31:0]        cmd_wdata_q, cmd_wdata_d;
  logic [3:0]         cmd_wmask_q, cmd_wmask_d;
  logic               wr_en_q, wr_en_d;
  logic [SRAM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]        wr_data_q, wr_data_d;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    bus_addr_d  = bus_addr_q;
    sram_addr_d = sram_addr_q;
    remain_d    = remain_q;
    wbuf_d      = wbuf_q;
    err_d       = err_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dir_d       = dir;
          bus_addr_d  = bus_addr;
          sram_addr_d = sram_addr;
          remain_d    = len_words;
          err_d       = 1'b0;
          if (len_words == '0) begin
            state_d = StFin;
          end else begin
            state_d = dir ? StSrd : StCmd;
          end
        end
      end
      StSrd:  state_d = StSlat;
      StSlat: begin
        wbuf_d  = sram_rd_data;
        state_d = StCmd;
      end
      StCmd: begin
        if (icb.icb_cmd_ready) state_d = StRsp;
      end
      StRsp: begin
        if (icb.icb_rsp_valid) begin
          if (icb.icb_rsp_err) begin
            // Abort: the failing word is never written locally.
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            if (!dir_q) begin
              wr_en_d   = 1'b1;
              wr_addr_d = sram_addr_q;
              wr_data_d = icb.icb_rsp_rdata;
            end
            bus_addr_d  = bus_addr_q + BUS_STRIDE;
            sram_addr_d = sram_addr_q + SRAM_AW'(1);
            remain_d    = remain_q - LEN_W'(1);
            if (remain_q == LEN_W'(1)) begin
              state_d = StFin;
            end else begin
              state_d = dir_q ? StSrd : StCmd;
            end
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Registered outputs are derived from next-state values so they line up
    // with the state they belong to.
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StFin);
    cmd_valid_d = (state_d == StCmd);
    cmd_read_d  = cmd_valid_d & ~dir_d;
    cmd_addr_d  = cmd_valid_d ? {bus_addr_d[31:2], 2'b00} : 32'h0;
    cmd_wdata_d = (cmd_valid_d && dir_d) ? wbuf_d : 32'h0;
    cmd_wmask_d = (cmd_valid_d && dir_d) ? WMASK_FULL : 4'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dir_q       <= 1'b0;
      bus_addr_q  <= '0;
      sram_addr_q <= '0;
      remain_q    <= '0;
      wbuf_q      <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_read_q  <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_wmask_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      bus_addr_q  <= bus_addr_d;
      sram_addr_q <= sram_addr_d;
      remain_q    <= remain_d;
      wbuf_q      <= wbuf_d;
      err_q       <= err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_read_q  <= cmd_read_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_wmask_q <= cmd_wmask_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign icb.icb_cmd_valid = cmd_valid_q;
  assign icb.icb_cmd_read  = cmd_read_q;
  assign icb.icb_cmd_addr  = cmd_addr_q;
  assign icb.icb_cmd_wdata = cmd_wdata_q;
  assign icb.icb_cmd_wmask = cmd_wmask_q;
  assign icb.icb_rsp_ready = (state_q == StRsp);
  assign sram_wr_en        = wr_en_q;
  assign sram_wr_addr      = wr_addr_q;
  assign sram_wr_data      = wr_data_q;
  assign sram_rd_en        = (state_q == StSrd);
  assign sram_rd_addr      = sram_addr_q;

endmodule

// File: tb/tb_icb_dma_master.sv
// Directed bench for icb_dma_master: ICB slave with configurable backpressure,
// local SRAM model, command/write logs and hand-computed expectations.
module tb_icb_dma_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [12:0] sram_addr = '0;
  logic [12:0] len_words = '0;
  logic        busy, done, err;
  logic        sram_wr_en, sram_rd_en;
  logic [12:0] sram_wr_addr, sram_rd_addr;
  logic [31:0] sram_wr_data;
  logic [31:0] sram_rd_data = '0;

  icb_dma_master_if icb ();

  icb_dma_master #(.SRAM_AW(13), .LEN_W(13)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .dir          (dir),
    .bus_addr     (bus_addr),
    .sram_addr    (sram_addr),
    .len_words    (len_words),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .icb          (icb),
    .sram_wr_en   (sram_wr_en),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .sram_rd_en   (sram_rd_en),
    .sram_rd_addr (sram_rd_addr),
    .sram_rd_data (sram_rd_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Slave / SRAM model configuration and logs
  int          ready_delay = 0;
  int          rsp_delay = 0;
  logic [31:0] rdata_base = '0;
  int          err_idx = -1;
  logic [31:0] mem [0:8191];
  int          n_cmds = 0, n_wr = 0, n_rd = 0, n_done = 0;
  logic [31:0] cmd_addr_log  [0:63];
  logic        cmd_read_log  [0:63];
  logic [31:0] cmd_wdata_log [0:63];
  logic [3:0]  cmd_wmask_log [0:63];
  logic [12:0] wr_addr_log   [0:63];
  logic [31:0] wr_data_log   [0:63];
  logic        overlap = 1'b0, unstable = 1'b0;

  // ICB slave and monitors, evaluated on the falling edge
  initial begin
    bit          pending, seen;
    int          wait_cnt, rsp_cnt, pend_idx;
    logic [68:0] snap;
    pending = 0; seen = 0; wait_cnt = 0; rsp_cnt = 0; pend_idx = 0; snap = '0;
    icb.icb_cmd_ready = 1'b0;
    icb.icb_rsp_valid = 1'b0;
    icb.icb_rsp_rdata = '0;
    icb.icb_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 0; seen = 0;
        icb.icb_cmd_ready = 1'b0;
        icb.icb_rsp_valid = 1'b0;
        icb.icb_rsp_err   = 1'b0;
      end else begin
        if (sram_wr_en) begin
          wr_addr_log[n_wr % 64] = sram_wr_addr;
          wr_data_log[n_wr % 64] = sram_wr_data;
          n_wr++;
        end
        if (sram_rd_en) begin
          sram_rd_data = mem[sram_rd_addr];
          n_rd++;
        end
        if (done) n_done++;
        icb.icb_cmd_ready = 1'b0;
        icb.icb_rsp_valid = 1'b0;
        icb.icb_rsp_err   = 1'b0;
        if (pending) begin
          if (icb.icb_cmd_valid) overlap = 1'b1;
          if (rsp_cnt >= rsp_delay) begin
            icb.icb_rsp_valid = 1'b1;
            icb.icb_rsp_rdata = rdata_base + 32'(pend_idx);
            icb.icb_rsp_err   = (pend_idx == err_idx);
            pending = 0;
          end else begin
            rsp_cnt++;
          end
        end else if (icb.icb_cmd_valid) begin
          if (!seen) begin
            seen = 1; wait_cnt = 0;
            snap = {icb.icb_cmd_read, icb.icb_cmd_addr, icb.icb_cmd_wdata, icb.icb_cmd_wmask};
          end else if (snap != {icb.icb_cmd_read, icb.icb_cmd_addr, icb.icb_cmd_wdata,
                                icb.icb_cmd_wmask}) begin
            unstable = 1'b1;
          end
          if (wait_cnt >= ready_delay) begin
            icb.icb_cmd_ready = 1'b1;
            cmd_addr_log[n_cmds % 64]  = icb.icb_cmd_addr;
            cmd_read_log[n_cmds % 64]  = icb.icb_cmd_read;
            cmd_wdata_log[n_cmds % 64] = icb.icb_cmd_wdata;
            cmd_wmask_log[n_cmds % 64] = icb.icb_cmd_wmask;
            pend_idx = n_cmds;
            n_cmds++;
            pending = 1; rsp_cnt = 0; seen = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  task automatic start_xfer(input logic d, input logic [31:0] ba, input logic [12:0] sa,
                            input logic [12:0] ln);
    @(negedge clk);
    dir = d; bus_addr = ba; sram_addr = sa; len_words = ln; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    check_eq("done_seen", 32'(got), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] out_or();
    return 32'(busy | done | err | icb.icb_cmd_valid | icb.icb_cmd_read | icb.icb_rsp_ready
                | sram_wr_en | sram_rd_en | (|icb.icb_cmd_wmask) | (|sram_wr_addr)
                | (|sram_rd_addr) | (|sram_wr_data));
  endfunction

  initial begin
    int c0, w0, r0, d0;
    mem[13'h010] = 32'h11;
    mem[13'h011] = 32'h22;

    // Reset state
    #12;
    check_eq("rst_ctl", out_or(), 32'd0);
    check_eq("rst_cmd_addr", icb.icb_cmd_addr, 32'd0);
    check_eq("rst_cmd_wdata", icb.icb_cmd_wdata, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Load
    c0 = n_cmds; w0 = n_wr; d0 = n_done;
    rdata_base = 32'hA0 - 32'(n_cmds);
    start_xfer(1'b0, 32'h8000_0000, 13'h0, 13'd4);
    check_eq("ld_busy", 32'(busy), 32'd1);
    wait_done();
    check_eq("ld_ncmd", n_cmds - c0, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("ld_cmd_addr", cmd_addr_log[c0 + i], 32'h8000_0000 + 32'(4 * i));
      check_eq("ld_cmd_read", 32'(cmd_read_log[c0 + i]), 32'd1);
      check_eq("ld_cmd_wmask", 32'(cmd_wmask_log[c0 + i]), 32'd0);
      check_eq("ld_wr_addr", 32'(wr_addr_log[w0 + i]), 32'(i));
      check_eq("ld_wr_data", wr_data_log[w0 + i], 32'hA0 + 32'(i));
    end
    check_eq("ld_nwr", n_wr - w0, 32'd4);
    check_eq("ld_ndone", n_done - d0, 32'd1);
    check_eq("ld_err", 32'(err), 32'd0);
    check_eq("ld_busy_end", 32'(busy), 32'd0);

    // Store
    c0 = n_cmds; w0 = n_wr; r0 = n_rd;
    start_xfer(1'b1, 32'h1004_2008, 13'h010, 13'd2);
    wait_done();
    check_eq("st_ncmd", n_cmds - c0, 32'd2);
    check_eq("st_addr0", cmd_addr_log[c0], 32'h1004_2008);
    check_eq("st_addr1", cmd_addr_log[c0 + 1], 32'h1004_200C);
    check_eq("st_wdata0", cmd_wdata_log[c0], 32'h11);
    check_eq("st_wdata1", cmd_wdata_log[c0 + 1], 32'h22);
    check_eq("st_wmask0", 32'(cmd_wmask_log[c0]), 32'hF);
    check_eq("st_wmask1", 32'(cmd_wmask_log[c0 + 1]), 32'hF);
    check_eq("st_read", 32'(cmd_read_log[c0]), 32'd0);
    check_eq("st_nrd", n_rd - r0, 32'd2);
    check_eq("st_nwr", n_wr - w0, 32'd0);

    // Backpressure, plus a start while busy that must be ignored
    ready_delay = 5; rsp_delay = 3;
    c0 = n_cmds; w0 = n_wr;
    rdata_base = 32'h5000 - 32'(n_cmds);
    start_xfer(1'b0, 32'h2000_0000, 13'h100, 13'd2);
    repeat (3) @(negedge clk);
    check_eq("bp_busy", 32'(busy), 32'd1);
    start_xfer(1'b1, 32'h5555_0000, 13'h7, 13'd7);
    wait_done();
    check_eq("bp_ncmd", n_cmds - c0, 32'd2);
    check_eq("bp_addr0", cmd_addr_log[c0], 32'h2000_0000);
    check_eq("bp_addr1", cmd_addr_log[c0 + 1], 32'h2000_0004);
    check_eq("bp_wr_addr1", 32'(wr_addr_log[w0 + 1]), 32'h101);
    check_eq("bp_wr_data1", wr_data_log[w0 + 1], 32'h5001);
    check_eq("bp_nwr", n_wr - w0, 32'd2);
    check_eq("bp_stable", 32'(unstable), 32'd0);
    check_eq("bp_overlap", 32'(overlap), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("bp_idle", 32'(busy), 32'd0);
    ready_delay = 0; rsp_delay = 0;

    // Zero length
    c0 = n_cmds; w0 = n_wr; r0 = n_rd;
    start_xfer(1'b0, 32'h8000_0000, 13'h0, 13'd0);
    check_eq("z_done", 32'(done), 32'd1);
    @(negedge clk);
    check_eq("z_done_off", 32'(done), 32'd0);
    check_eq("z_busy_off", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("z_ncmd", n_cmds - c0, 32'd0);
    check_eq("z_nsram", (n_wr - w0) + (n_rd - r0), 32'd0);

    // Error on word 2
    c0 = n_cmds; w0 = n_wr; d0 = n_done;
    err_idx = n_cmds + 2;
    rdata_base = 32'hB0 - 32'(n_cmds);
    start_xfer(1'b0, 32'h4000_0000, 13'h20, 13'd4);
    wait_done();
    check_eq("er_err", 32'(err), 32'd1);
    check_eq("er_ncmd", n_cmds - c0, 32'd3);
    check_eq("er_nwr", n_wr - w0, 32'd2);
    check_eq("er_wr_addr1", 32'(wr_addr_log[w0 + 1]), 32'h21);
    check_eq("er_ndone", n_done - d0, 32'd1);
    repeat (5) @(negedge clk);
    check_eq("er_sticky", 32'(err), 32'd1);
    err_idx = -1;

    // Address wrap
    c0 = n_cmds; w0 = n_wr;
    rdata_base = 32'hA0 - 32'(n_cmds);
    start_xfer(1'b0, 32'hFFFF_FFFC, 13'h1FFF, 13'd2);
    check_eq("wr_err_clr", 32'(err), 32'd0);
    wait_done();
    check_eq("wr_addr0", cmd_addr_log[c0], 32'hFFFF_FFFC);
    check_eq("wr_addr1", cmd_addr_log[c0 + 1], 32'h0000_0000);
    check_eq("wr_sram0", 32'(wr_addr_log[w0]), 32'h1FFF);
    check_eq("wr_sram1", 32'(wr_addr_log[w0 + 1]), 32'h0);
    check_eq("wr_data1", wr_data_log[w0 + 1], 32'hA1);

    // Reset mid-transfer
    rsp_delay = 3;
    c0 = n_cmds;
    start_xfer(1'b0, 32'h3000_0000, 13'h40, 13'd4);
    for (int i = 0; i < 100 && (n_cmds - c0) < 1; i++) @(negedge clk);
    check_eq("mr_started", 32'((n_cmds - c0) >= 1), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_outs", out_or(), 32'd0);
    check_eq("mr_cmd_addr", icb.icb_cmd_addr, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    c0 = n_cmds; w0 = n_wr; r0 = n_rd; d0 = n_done;
    repeat (20) @(negedge clk);
    check_eq("mr_ncmd", n_cmds - c0, 32'd0);
    check_eq("mr_nwr", n_wr - w0, 32'd0);
    check_eq("mr_ndone", n_done - d0, 32'd0);
    check_eq("mr_idle", out_or(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/icb_dma_master.md
ICB_DMA_MASTER -- requirements
Module: icb_dma_master

Interface
REQ-001 SHALL have parameter SRAM_AW, default 13, meaning local SRAM word-address width.
REQ-002 SHALL have parameter LEN_W, default 13, meaning transfer-length counter width in words.
REQ-003 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a transfer.
REQ-006 SHALL have port dir, input, 1, 0 = bus->SRAM (load), 1 = SRAM->bus (store); sampled with start.
REQ-007 SHALL have port bus_addr, input, 32, byte start address on ICB; sampled with start.
REQ-008 SHALL have port sram_addr, input, SRAM_AW, SRAM word start address; sampled with start.
REQ-009 SHALL have port len_words, input, LEN_W, number of 32-bit words; sampled with start.
REQ-010 SHALL have ports busy (out,1), done (out,1, one-cycle pulse) and err (out,1, sticky).
REQ-011 SHALL have ICB master ports: icb_cmd_valid out 1, icb_cmd_ready in 1, icb_cmd_read out 1, icb_cmd_addr out 32, icb_cmd_wdata out 32, icb_cmd_wmask out 4, icb_rsp_valid in 1, icb_rsp_ready out 1, icb_rsp_rdata in 32, icb_rsp_err in 1.
REQ-012 SHALL have SRAM ports: sram_wr_en out 1, sram_wr_addr out SRAM_AW, sram_wr_data out 32, sram_rd_en out 1, sram_rd_addr out SRAM_AW, sram_rd_data in 32 (valid one cycle after sram_rd_en).

Function
REQ-013 SHALL implement states IDLE, SRD, SLAT, CMD, RSP, FIN; exactly one ICB transaction outstanding at any time.
REQ-014 IDLE: start with len_words!=0 -> CMD (dir=0) or SRD (dir=1), latch parameters, clear err, busy=1 next cycle; start with len_words==0 -> FIN, no bus or SRAM activity.
REQ-015 start while busy SHALL be ignored; latched parameters unchanged.
REQ-016 SRD: sram_rd_en=1 for exactly one cycle at current SRAM address -> SLAT; SLAT: capture sram_rd_data into write-data register -> CMD.
REQ-017 CMD: icb_cmd_valid=1, icb_cmd_read=~dir, icb_cmd_addr=current bus address with bits[1:0]=0, icb_cmd_wdata=captured data (0 when reading), icb_cmd_wmask=4'hF for writes, 4'h0 for reads; all held stable until icb_cmd_ready=1, then -> RSP.
REQ-018 RSP: icb_rsp_ready=1 (0 in all other states); on icb_rsp_valid: if dir=0 register sram_wr_en=1, sram_wr_data=icb_rsp_rdata, sram_wr_addr=current SRAM address for exactly the next cycle.
REQ-019 On each response without error: bus address +4 (modulo 2^32), SRAM address +1 (modulo 2^SRAM_AW), remaining count -1; remaining==0 -> FIN, else -> CMD (dir=0) or SRD (dir=1).
REQ-020 icb_rsp_err=1 on a response SHALL set err, suppress that word's SRAM write, and go to FIN (abort).
REQ-021 FIN: done=1 for one cycle, busy=0 next cycle, -> IDLE; err held until next accepted start.
REQ-022 Outputs SHALL be registered except icb_rsp_ready and sram_rd_en, which are decoded from state only.

Reset
REQ-023 Reset SHALL force state IDLE and all outputs 0 (busy, done, err, icb_cmd_*, icb_rsp_ready, sram_*), counters and address registers 0.
REQ-024 Reset mid-transfer SHALL abandon the transfer immediately with no further ICB command or SRAM write after release.

Structure
REQ-025 State enum and constants (WMASK_FULL=4'hF, BUS_STRIDE=4) SHALL live in shared package acc_icb_pkg.
REQ-026 No sub-module required; single module, one FSM plus datapath registers.

Verification
REQ-027 Load: dir=0, bus_addr=0x8000_0000, sram_addr=0, len=4, slave returns 0xA0..0xA3 -> SRAM words 0..3 = 0xA0..0xA3, 4 read commands at 0x8000_0000..0x8000_000C, one done pulse.
REQ-028 Store: dir=1, sram_addr=0x10 holding 0x11,0x22, len=2, bus_addr=0x1004_2008 -> two writes, wmask 4'hF, wdata 0x11 then 0x22, addresses 0x1004_2008/0x1004_200C.
REQ-029 Backpressure: icb_cmd_ready low 5 cycles, rsp delayed 3 cycles -> cmd fields stable throughout, exactly one outstanding, correct data.
REQ-030 len=0 -> done one cycle after start, zero ICB/SRAM activity; start during busy ignored.
REQ-031 Error: len=4, icb_rsp_err on word 2 -> err=1, SRAM words 0,1 written only, done pulse, no further commands.
REQ-032 Wrap: bus_addr=0xFFFF_FFFC, sram_addr=0x1FFF, len=2 -> second access bus 0x0000_0000, SRAM address 0; reset asserted mid-transfer -> all outputs 0, no activity after release.
